// File: rtl/serial_magnitude_select.sv
// Iterative MSB-first magnitude comparator: scans two operands BPC bits per cycle
// from the top down and returns the larger or smaller one (signed or unsigned).
//
// state | meaning
// IDLE  | waiting for start; last result held on outputs
// SCAN  | examining one BPC-bit group per cycle, top group first
module serial_magnitude_select #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1,
    parameter int CW    = $clog2(WIDTH/BPC+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode_min,
    input  logic             mode_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             a_wins,
    output logic             tie,
    output logic [CW-1:0]    cycles
);

    localparam int NG = WIDTH / BPC;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [GW-1:0] G_TOP = GW'(NG - 1);

    generate
        if (WIDTH < 2 || (WIDTH % BPC) != 0) begin : g_bad_param
            $error("serial_magnitude_select: WIDTH must be >= 2 and a multiple of BPC");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic             min_q, min_n;
    logic             signed_q, signed_n;
    logic [GW-1:0]    g_q, g_n;
    logic [CW-1:0]    cnt_q, cnt_n;

    logic             busy_n;
    logic             done_n;
    logic [WIDTH-1:0] result_n;
    logic             a_wins_n;
    logic             tie_n;
    logic [CW-1:0]    cycles_n;

    logic [BPC-1:0]   grp_a;
    logic [BPC-1:0]   grp_b;
    logic [BPC-1:0]   grp_diff;
    logic             found;
    logic             hi_a;
    logic             hi_top;
    logic             sign_flip;
    logic             win_a;
    logic [CW-1:0]    cnt_inc;

    // Group select by constant slices keeps the mux free of variable shifts.
    always_comb begin
        grp_a = '0;
        grp_b = '0;
        for (int j = 0; j < NG; j++) begin
            if (g_q == GW'(j)) begin
                grp_a = a_q[j*BPC +: BPC];
                grp_b = b_q[j*BPC +: BPC];
            end
        end
    end

    assign grp_diff = grp_a ^ grp_b;

    // Ascending scan: the last hit is the most significant differing bit.
    always_comb begin
        found  = 1'b0;
        hi_a   = 1'b0;
        hi_top = 1'b0;
        for (int i = 0; i < BPC; i++) begin
            if (grp_diff[i]) begin
                found  = 1'b1;
                hi_a   = grp_a[i];
                hi_top = (i == BPC - 1);
            end
        end
    end

    // A sign-bit difference means the operand holding 0 is the larger one.
    assign sign_flip = signed_q && (g_q == G_TOP) && hi_top;
    assign win_a     = hi_a ^ sign_flip ^ min_q;
    assign cnt_inc   = cnt_q + CW'(1);

    always_comb begin
        state_n  = state_q;
        a_n      = a_q;
        b_n      = b_q;
        min_n    = min_q;
        signed_n = signed_q;
        g_n      = g_q;
        cnt_n    = cnt_q;
        busy_n   = busy;
        done_n   = 1'b0;
        result_n = result;
        a_wins_n = a_wins;
        tie_n    = tie;
        cycles_n = cycles;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_n      = a;
                    b_n      = b;
                    min_n    = mode_min;
                    signed_n = mode_signed;
                    g_n      = G_TOP;
                    cnt_n    = '0;
                    busy_n   = 1'b1;
                    state_n  = SCAN;
                end
            end
            SCAN: begin
                if (found) begin
                    result_n = win_a ? a_q : b_q;
                    a_wins_n = win_a;
                    tie_n    = 1'b0;
                    cycles_n = cnt_inc;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end else if (g_q == '0) begin
                    result_n = a_q;
                    a_wins_n = 1'b0;
                    tie_n    = 1'b1;
                    cycles_n = cnt_inc;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end else begin
                    g_n   = g_q - GW'(1);
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            min_q    <= 1'b0;
            signed_q <= 1'b0;
            g_q      <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            a_wins   <= 1'b0;
            tie      <= 1'b0;
            cycles   <= '0;
        end else begin
            state_q  <= state_n;
            a_q      <= a_n;
            b_q      <= b_n;
            min_q    <= min_n;
            signed_q <= signed_n;
            g_q      <= g_n;
            cnt_q    <= cnt_n;
            busy     <= busy_n;
            done     <= done_n;
            result   <= result_n;
            a_wins   <= a_wins_n;
            tie      <= tie_n;
            cycles   <= cycles_n;
        end
    end

endmodule
